score_uart_tx: RTL and testbench
================================

// Module: score_uart_tx
// PURPOSE
//   Transmits each Smith-Waterman score over UART_TXD as ASCII hex text ("2A5F3\r\n").
//   Sits beside the board-level score display: FPGAWrapper o_result/o_valid feed i_data/i_valid.
//   o_txd drives UART_TXD. Format is 8N1, LSB first, one frame per accepted score.
// PARAMETERS
//   CLK_FREQ  50_000_000  clk frequency in Hz
//   BAUD      115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (434 at defaults, integer division)
//   DATA_W    18          score width; NUM_DIGITS = (DATA_W+3)/4 (5 at defaults)
// PORTS
//   clk      in   1       system clock
//   rst      in   1       synchronous reset, active-high
//   i_valid  in   1       single-cycle strobe; i_data is a new score
//   i_data   in   DATA_W  score value, unsigned
//   o_txd    out  1       UART serial out; idles high
//   o_busy   out  1       high while a frame is transmitting or a score is pending
//   o_done   out  1       one-cycle pulse after the last stop bit of a frame
//   o_drop   out  1       one-cycle pulse when an i_valid is discarded
// BEHAVIOUR
//   Reset values (applied on the cycle after rst is sampled high): o_txd=1, o_busy=0, o_done=0,
//   o_drop=0, pending buffer empty, FSM=IDLE.
//   rst mid-frame aborts the frame immediately and discards any pending score.
//   Frame: NUM_DIGITS hex chars MSB-nibble first, then 0x0D, then 0x0A.
//     The top nibble is zero-extended.
//     Nibble mapping: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10), uppercase.
//   Char: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
//     Characters are back-to-back with no extra idle between them.
//   Latency: i_valid accepted in IDLE at cycle t -> start bit on o_txd from cycle t+1.
//   Buffering: an active shift register plus a 1-entry pending register.
//     i_valid in IDLE: score latched into active, frame starts.
//     i_valid while busy, pending empty: score stored in pending.
//     i_valid while busy, pending full: score dropped, o_drop=1 for that cycle; pending unchanged.
//   End of frame (last stop-bit cycle completes):
//     o_done pulses.
//     If pending is full, its score moves to active and the next start bit begins on the following
//     cycle; o_busy stays high.
//     Otherwise FSM -> IDLE and o_busy falls on the same cycle as o_done.
//   i_valid coincident with end of frame:
//     Pending empty: the new score goes to pending, then is promoted at once; no drop.
//     Pending full: the old pending is promoted and the new score takes pending; no drop.
//   FSM states: IDLE -> START -> DATA (8 bits) -> STOP -> (next char ? START : FRAME_END)
//     -> (pending ? START : IDLE).
//     FRAME_END is combinational with the last STOP cycle; it adds no cycle.
//   Counters:
//     baud counter 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary;
//     bit index 0..7;
//     char index 0..NUM_DIGITS+1.
//   o_busy = (FSM != IDLE) | pending_full.
// STRUCTURE
//   Package sw_uart_pkg holds:
//     ASCII_CR = 8'h0D, ASCII_LF = 8'h0A, ASCII_0 = 8'h30, ASCII_A = 8'h41;
//     the frame-state enum;
//     function nibble_to_ascii().
//   Sub-module uart_byte_tx (clk, rst, i_start, i_byte[7:0], o_txd, o_ready, o_byte_done).
//     It owns the baud counter and bit serializer, parameterised by CLKS_PER_BIT.
//   score_uart_tx owns the frame FSM, the char sequencer and the pending buffer.
// TESTING
//   1. Reset: hold rst 3 cycles, release -> o_txd=1, o_busy=0, and no pulses for 1000 cycles.
//   2. i_valid with 18'h2A5F3 -> line decodes to 32 41 35 46 33 0D 0A.
//      Each bit is 434 clocks; o_done pulses 7*10*434=30380 cycles after acceptance.
//   3. Boundaries: 18'h0 -> "00000\r\n"; 18'h3FFFF -> "3FFFF\r\n".
//   4. Three i_valid at t, t+5, t+10 with 1, 2, 3 -> frames "00001" then "00002".
//      o_drop pulses at t+10; score 3 is never sent. There is no idle gap between the frames.
//   5. i_valid on the exact end-of-frame cycle, pending empty -> no o_drop.
//      The new frame starts on the next cycle.
//   6. rst asserted mid-DATA of char 3 -> o_txd=1 and o_busy=0 on the next cycle.
//      A subsequent i_valid transmits normally.

Source files
------------

// File: rtl/sw_uart_pkg.sv
// ============================================================================
// Module : sw_uart_pkg
// Brief  : Shared constants, state encodings and ASCII helper for the score UART.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [0:0] {
      FR_IDLE = 1'b0,
      FR_SEND = 1'b1
   } frame_state_t;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10)
         return ASCII_0 + {4'h0, nib};
      else
         return ASCII_A + ({4'h0, nib} - 8'd10);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module : uart_byte_tx
// Brief  : 8N1 byte serializer; accepts a new byte on the last stop cycle so
//          consecutive characters leave no idle gap.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_tx
   import sw_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_txd,
   output logic       o_ready,
   output logic       o_byte_done
);

   localparam int              BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   tx_state_t         r_state;
   tx_state_t         w_state_nxt;
   logic [BAUD_W-1:0] r_baud;
   logic [2:0]        r_bit;
   logic [7:0]        r_shift;
   logic              w_bit_end;
   logic              w_load;

   assign w_bit_end   = (r_state != TX_IDLE) && (r_baud == C_BAUD_LAST);
   assign o_byte_done = (r_state == TX_STOP) && w_bit_end;
   assign o_ready     = (r_state == TX_IDLE) || o_byte_done;
   assign w_load      = o_ready && i_start;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= TX_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TX_IDLE:  if (i_start) w_state_nxt = TX_START;
         TX_START: if (w_bit_end) w_state_nxt = TX_DATA;
         TX_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = TX_STOP;
         TX_STOP:  if (w_bit_end) w_state_nxt = i_start ? TX_START : TX_IDLE;
         default:  w_state_nxt = TX_IDLE;
      endcase
   end

   // r_bit wraps 7 -> 0 on its own, so it is already cleared for the next byte
   always_ff @(posedge clk) begin
      if (rst) begin
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         r_baud <= ((r_state == TX_IDLE) || w_bit_end) ? '0 : r_baud + BAUD_W'(1);
         if ((r_state == TX_DATA) && w_bit_end)
            r_bit <= r_bit + 3'd1;
         if (w_load)
            r_shift <= i_byte;
         else if ((r_state == TX_DATA) && w_bit_end)
            r_shift <= {1'b0, r_shift[7:1]};
      end
   end

   always_comb begin
      o_txd = 1'b1;
      case (r_state)
         TX_START: o_txd = 1'b0;
         TX_DATA:  o_txd = r_shift[0];
         default:  o_txd = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/score_uart_tx.sv
// ============================================================================
// Module : score_uart_tx
// Brief  : Sends each score as uppercase hex text plus CR LF over an 8N1 UART,
//          with one pending slot behind the frame in flight.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_uart_tx
   import sw_uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115_200,
   parameter int DATA_W   = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_txd,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_drop
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int NUM_DIGITS   = (DATA_W + 3) / 4;
   localparam int NUM_CHARS    = NUM_DIGITS + 2;
   localparam int PAD_W        = NUM_DIGITS * 4;
   localparam int CHAR_W       = $clog2(NUM_CHARS);
   localparam logic [CHAR_W-1:0] C_LAST_CHAR = CHAR_W'(NUM_CHARS - 1);

   function automatic logic [7:0] char_byte(input logic [DATA_W-1:0] score,
                                            input logic [CHAR_W-1:0] idx);
      logic [PAD_W-1:0] padded;
      int               shamt;
      padded = PAD_W'(score);
      if (int'(idx) < NUM_DIGITS) begin
         shamt = 4 * (NUM_DIGITS - 1 - int'(idx));
         return nibble_to_ascii(padded[shamt +: 4]);
      end else if (int'(idx) == NUM_DIGITS) begin
         return ASCII_CR;
      end else begin
         return ASCII_LF;
      end
   endfunction

   frame_state_t      r_state;
   frame_state_t      w_state_nxt;
   logic [DATA_W-1:0] r_active;
   logic [DATA_W-1:0] r_pend;
   logic              r_pend_full;
   logic [CHAR_W-1:0] r_char;
   logic              r_done;

   logic              w_sending;
   logic              w_byte_done;
   logic              w_tx_ready;
   logic              w_last_char;
   logic              w_frame_end;
   logic              w_next_char;
   logic              w_start_frame;
   logic              w_drop;
   logic [DATA_W-1:0] w_new_score;
   logic              w_tx_start;
   logic [7:0]        w_tx_byte;
   logic              w_txd;

   assign w_sending   = (r_state == FR_SEND);
   assign w_last_char = (r_char == C_LAST_CHAR);
   assign w_frame_end = w_sending && w_byte_done && w_last_char;
   assign w_next_char = w_sending && w_byte_done && !w_last_char;

   // A new frame's first byte comes straight from its source so the start bit is not delayed
   assign w_start_frame = (!w_sending && i_valid) || (w_frame_end && (r_pend_full || i_valid));
   assign w_new_score   = (w_frame_end && r_pend_full) ? r_pend : i_data;
   assign w_drop        = w_sending && !w_frame_end && i_valid && r_pend_full;
   assign w_tx_start    = w_start_frame || w_next_char;
   assign w_tx_byte     = w_start_frame ? char_byte(w_new_score, '0)
                                        : char_byte(r_active, r_char + CHAR_W'(1));

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_tx_start),
      .i_byte      (w_tx_byte),
      .o_txd       (w_txd),
      .o_ready     (w_tx_ready),
      .o_byte_done (w_byte_done)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= FR_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FR_IDLE: if (i_valid) w_state_nxt = FR_SEND;
         FR_SEND: if (w_frame_end && !(r_pend_full || i_valid)) w_state_nxt = FR_IDLE;
         default: w_state_nxt = FR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active    <= '0;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
         r_char      <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_frame_end;
         if (w_start_frame) begin
            r_active <= w_new_score;
            r_char   <= '0;
         end else if (w_next_char) begin
            r_char <= r_char + CHAR_W'(1);
         end
         // At frame end an empty slot lets i_data go straight to active
         if (w_frame_end) begin
            if (r_pend_full && i_valid)
               r_pend <= i_data;
            else if (r_pend_full)
               r_pend_full <= 1'b0;
         end else if (w_sending && i_valid && !r_pend_full) begin
            r_pend      <= i_data;
            r_pend_full <= 1'b1;
         end
      end
   end

   always_comb begin
      o_txd  = w_txd;
      o_busy = (r_state != FR_IDLE) || r_pend_full;
      o_done = r_done;
      o_drop = w_drop;
   end

endmodule

`default_nettype wire

// File: tb/tb_score_uart_tx.sv
// ============================================================================
// Module : tb_score_uart_tx
// Brief  : Directed bench for score_uart_tx; decodes the serial line and checks
//          text, frame timing, pending/drop handling and mid-frame reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_uart_tx;

   localparam int CPB   = 16;            // 1_600_000 / 100_000
   localparam int FRAME = 7 * 10 * CPB;   // cycles per 7-char frame
   localparam int RX_TO = 3 * FRAME;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [17:0] i_data = '0;
   logic        o_txd;
   logic        o_busy;
   logic        o_done;
   logic        o_drop;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int drop_cnt = 0;
   int low_cnt = 0;
   int done_cyc = 0;

   score_uart_tx #(
      .CLK_FREQ (1_600_000),
      .BAUD     (100_000),
      .DATA_W   (18)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_txd   (o_txd),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_drop  (o_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (o_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (o_drop) drop_cnt <= drop_cnt + 1;
         if (!o_txd) low_cnt <= low_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Called on a negedge; holds i_valid for one cycle and checks o_drop mid-cycle
   task automatic pulse(input logic [17:0] d, input logic exp_drop, input string tag);
      i_valid = 1'b1;
      i_data  = d;
      #3;
      check(tag, {31'd0, o_drop}, {31'd0, exp_drop});
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic rx_char(output logic [7:0] b, output int start_cyc);
      int guard;
      guard = 0;
      while (o_txd !== 1'b0 && guard < RX_TO) begin
         @(negedge clk);
         guard++;
      end
      check("rx_start_timeout", {31'd0, guard >= RX_TO}, 32'd0);
      start_cyc = cyc;
      repeat (CPB / 2) @(negedge clk);
      check("rx_start_bit", {31'd0, o_txd}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         b[i] = o_txd;
      end
      repeat (CPB) @(negedge clk);
      check("rx_stop_bit", {31'd0, o_txd}, 32'd1);
   endtask

   task automatic rx_frame(input string s, output int first);
      logic [7:0] b;
      logic [7:0] exp;
      int         st;
      first = 0;
      for (int i = 0; i < 7; i++) begin
         rx_char(b, st);
         if (i == 0) first = st;
         exp = (i < 5) ? 8'(s.getc(i)) : ((i == 5) ? 8'h0D : 8'h0A);
         check($sformatf("%s_char%0d", s, i), {24'd0, b}, {24'd0, exp});
      end
   endtask

   task automatic run_frame(input logic [17:0] d, input string s);
      int acc;
      int s1;
      int d0;
      d0 = done_cnt;
      acc = 0;
      fork
         begin
            pulse(d, 1'b0, {s, "_accept_drop"});
            acc = cyc;
            check({s, "_busy_after_accept"}, {31'd0, o_busy}, 32'd1);
            check({s, "_start_latency"}, {31'd0, o_txd}, 32'd0);
         end
         rx_frame(s, s1);
      join
      check({s, "_first_start_cyc"}, s1, acc);
      repeat (2 * CPB) @(negedge clk);
      check({s, "_done_latency"}, done_cyc - acc, FRAME);
      check({s, "_done_count"}, done_cnt - d0, 1);
      check({s, "_busy_after"}, {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s1, s2, d0, p0, l0;

      // Test 1: reset and quiet idle line
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_txd", {31'd0, o_txd}, 32'd1);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_done", {31'd0, o_done}, 32'd0);
      check("rst_drop", {31'd0, o_drop}, 32'd0);
      repeat (1000) @(negedge clk);
      check("idle_done_cnt", done_cnt, 0);
      check("idle_drop_cnt", drop_cnt, 0);
      check("idle_low_cnt", low_cnt, 0);

      // Tests 2/3: main pattern and boundaries
      run_frame(18'h2A5F3, "2A5F3");
      run_frame(18'h00000, "00000");
      run_frame(18'h3FFFF, "3FFFF");

      // Test 4: pending then drop; frames back to back
      d0 = done_cnt;
      p0 = drop_cnt;
      fork
         begin
            pulse(18'd1, 1'b0, "t4_v1_drop");
            repeat (4) @(negedge clk);
            pulse(18'd2, 1'b0, "t4_v2_drop");
            repeat (4) @(negedge clk);
            pulse(18'd3, 1'b1, "t4_v3_drop");
         end
         begin
            rx_frame("00001", s1);
            rx_frame("00002", s2);
         end
      join
      check("t4_gap", s2 - s1, FRAME);
      repeat (2 * CPB) @(negedge clk);
      check("t4_busy_after", {31'd0, o_busy}, 32'd0);
      check("t4_done_count", done_cnt - d0, 2);
      check("t4_drop_count", drop_cnt - p0, 1);
      l0 = low_cnt;
      repeat (FRAME) @(negedge clk);
      check("t4_no_third_frame", low_cnt - l0, 0);

      // Test 5: i_valid on the exact last stop cycle
      d0 = done_cnt;
      p0 = drop_cnt;
      fork
         begin
            pulse(18'd4, 1'b0, "t5_v4_drop");
            repeat (FRAME - 1) @(negedge clk);
            pulse(18'd5, 1'b0, "t5_endframe_drop");
            check("t5_busy_held", {31'd0, o_busy}, 32'd1);
            check("t5_done_pulse", {31'd0, o_done}, 32'd1);
         end
         begin
            rx_frame("00004", s1);
            rx_frame("00005", s2);
         end
      join
      check("t5_gap", s2 - s1, FRAME);
      repeat (2 * CPB) @(negedge clk);
      check("t5_done_count", done_cnt - d0, 2);
      check("t5_drop_count", drop_cnt - p0, 0);
      check("t5_busy_after", {31'd0, o_busy}, 32'd0);

      // Test 6: reset in the middle of char 3 data bits, with a score pending
      d0 = done_cnt;
      pulse(18'h12345, 1'b0, "t6_v_drop");
      repeat (4) @(negedge clk);
      pulse(18'd7, 1'b0, "t6_pend_drop");
      repeat (3 * 10 * CPB + 3 * CPB - 5) @(negedge clk);
      check("t6_busy_mid", {31'd0, o_busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_txd", {31'd0, o_txd}, 32'd1);
      check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
      rst = 1'b0;
      check("t6_aborted_no_done", done_cnt - d0, 0);
      run_frame(18'h00ABC, "00ABC");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
